// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module   : inst_fetch_pkg
// Brief    : Shared constants and state encoding for the instruction fetch unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

    localparam int          c_bht_entries = 256;
    localparam logic [31:0] c_reset_pc    = 32'h0000_0000;

    localparam logic [6:0]  c_op_branch   = 7'd99;
    localparam logic [6:0]  c_op_jal      = 7'd111;
    localparam logic [6:0]  c_op_jalr     = 7'd103;

    localparam int          c_state_w     = 2;
    typedef logic [c_state_w-1:0] fetch_state_t;

    localparam fetch_state_t c_st_idle     = 2'd0;
    localparam fetch_state_t c_st_wait_mem = 2'd1;
    localparam fetch_state_t c_st_hold     = 2'd2;
    localparam fetch_state_t c_st_drop     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : Table of 2-bit saturating counters with registered training and
//            combinational lookup (lookup sees the pre-update value)
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import inst_fetch_pkg::*;
#(
    parameter int BHT_ENTRIES = c_bht_entries,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             bp_update,
    input  logic [IDX_W-1:0] bp_idx,
    input  logic             bp_taken,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             pred_taken
);

    logic [1:0] r_cnt [BHT_ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_cnt[i] <= 2'b01;
            end
        end else if (rdy && bp_update) begin
            if (bp_taken) begin
                if (r_cnt[bp_idx] != 2'b11) begin
                    r_cnt[bp_idx] <= r_cnt[bp_idx] + 2'd1;
                end
            end else if (r_cnt[bp_idx] != 2'b00) begin
                r_cnt[bp_idx] <= r_cnt[bp_idx] - 2'd1;
            end
        end
    end

    assign pred_taken = r_cnt[lookup_idx][1];

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Brief    : Single-outstanding instruction fetch with static JAL and BHT-based
//            branch prediction, misprediction flush and decoder back-pressure
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          BHT_ENTRIES = c_bht_entries,
    parameter logic [31:0] RESET_PC    = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic [31:0] jp_target,
    input  logic        bp_update,
    input  logic [31:0] bp_pc,
    input  logic        bp_taken,
    input  logic        stall_IF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        ins_flag,
    output logic [31:0] ins,
    output logic        jp_flag,
    output logic [31:0] jp_pc
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_ins;
    logic        r_ins_flag;
    logic        r_jp_flag;
    logic [31:0] r_jp_pc;

    logic        w_bht_taken;
    logic        w_pred_taken;
    logic [31:0] w_next_pc;
    logic        w_outstanding;
    logic        w_unused_bp_pc;

    branch_predictor #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bp (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .bp_update  (bp_update),
        .bp_idx     (bp_pc[IDX_W+1:2]),
        .bp_taken   (bp_taken),
        .lookup_idx (r_pc[IDX_W+1:2]),
        .pred_taken (w_bht_taken)
    );

    assign w_unused_bp_pc = ^{bp_pc[31:IDX_W+2], bp_pc[1:0]};

    // Prediction is made on the word arriving this cycle, at the PC it was fetched from
    always_comb begin
        w_pred_taken = 1'b0;
        w_next_pc    = r_pc + 32'd4;
        case (mem_data[6:0])
            c_op_jal: begin
                w_pred_taken = 1'b1;
                w_next_pc    = r_pc + {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                                       mem_data[20], mem_data[30:21], 1'b0};
            end
            c_op_branch: begin
                if (w_bht_taken) begin
                    w_pred_taken = 1'b1;
                    w_next_pc    = r_pc + {{19{mem_data[31]}}, mem_data[31], mem_data[7],
                                           mem_data[30:25], mem_data[11:8], 1'b0};
                end
            end
            c_op_jalr: begin
                w_pred_taken = 1'b0;
            end
            default: begin
                w_pred_taken = 1'b0;
            end
        endcase
    end

    assign w_outstanding = ((r_state == c_st_wait_mem) || (r_state == c_st_drop)) && !mem_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (jp_wrong) begin
            w_state_nxt = w_outstanding ? c_st_drop : c_st_idle;
        end else if (rdy) begin
            case (r_state)
                c_st_idle:     w_state_nxt = c_st_wait_mem;
                c_st_wait_mem: if (mem_valid) w_state_nxt = c_st_hold;
                c_st_hold:     if (!stall_IF) w_state_nxt = c_st_idle;
                c_st_drop:     if (mem_valid) w_state_nxt = c_st_idle;
                default:       w_state_nxt = c_st_idle;
            endcase
        end
    end

    // The request is withheld on a flush cycle so no fetch ever targets a stale PC
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = 32'h0;
        if (rst) begin
            case (r_state)
                c_st_idle: begin
                    if (rdy && !jp_wrong) begin
                        mem_req  = 1'b1;
                        mem_addr = r_pc;
                    end
                end
                c_st_wait_mem, c_st_drop: begin
                    mem_req  = 1'b1;
                    mem_addr = r_req_addr;
                end
                default: begin
                    mem_req  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= 32'h0;
            r_ins      <= 32'h0;
            r_ins_flag <= 1'b0;
            r_jp_flag  <= 1'b0;
            r_jp_pc    <= 32'h0;
        end else if (jp_wrong) begin
            r_pc       <= jp_target;
            r_ins_flag <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                c_st_idle: begin
                    r_req_addr <= r_pc;
                end
                c_st_wait_mem: begin
                    if (mem_valid) begin
                        r_ins      <= mem_data;
                        r_jp_pc    <= r_pc;
                        r_jp_flag  <= w_pred_taken;
                        r_ins_flag <= 1'b1;
                        r_pc       <= w_next_pc;
                    end
                end
                c_st_hold: begin
                    if (!stall_IF) begin
                        r_ins_flag <= 1'b0;
                    end
                end
                default: begin
                    r_ins_flag <= 1'b0;
                end
            endcase
        end
    end

    assign ins_flag = r_ins_flag;
    assign ins      = r_ins;
    assign jp_flag  = r_jp_flag;
    assign jp_pc    = r_jp_pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed self-checking bench for inst_fetch with a latency-driven
//            instruction memory model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        rdy       = 1'b0;
    logic        jp_wrong  = 1'b0;
    logic [31:0] jp_target = 32'h0;
    logic        bp_update = 1'b0;
    logic [31:0] bp_pc     = 32'h0;
    logic        bp_taken  = 1'b0;
    logic        stall_IF  = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data  = 32'h0;
    logic        ins_flag;
    logic [31:0] ins;
    logic        jp_flag;
    logic [31:0] jp_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 2;
    int mem_cnt  = 0;
    logic stable;
    logic stale;
    logic found;

    inst_fetch #(
        .BHT_ENTRIES (256),
        .RESET_PC    (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .jp_wrong  (jp_wrong),
        .jp_target (jp_target),
        .bp_update (bp_update),
        .bp_pc     (bp_pc),
        .bp_taken  (bp_taken),
        .stall_IF  (stall_IF),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .ins_flag  (ins_flag),
        .ins       (ins),
        .jp_flag   (jp_flag),
        .jp_pc     (jp_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // 8: jal x0,16 ; 0x40: beq x0,x0,+8 ; everything else a nop
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0008: return 32'h0100_006F;
            32'h0000_0040: return 32'h0000_0463;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (mem_req) begin
                if (mem_cnt >= mem_lat) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_word(mem_addr);
                    mem_cnt   = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic wait_ins(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ins_flag) break;
        end
        if (!ins_flag) check_eq({tag, "_timeout"}, ins_flag, 1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        check_eq(tag, mem_req ? mem_addr : 32'hDEAD_BEEF, exp_addr);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(negedge clk);
        jp_wrong  = 1'b1;
        jp_target = tgt;
        @(negedge clk);
        jp_wrong  = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bp_update = 1'b1;
            bp_pc     = pc;
            bp_taken  = taken;
        end
        @(negedge clk);
        bp_update = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req",  mem_req,  0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_ins_flag", ins_flag, 0);
        check_eq("rst_ins",      ins,      0);
        check_eq("rst_jp_flag",  jp_flag,  0);
        check_eq("rst_jp_pc",    jp_pc,    0);

        rst = 1'b1;
        #1;
        check_eq("first_req",  mem_req,  1);
        check_eq("first_addr", mem_addr, 32'h0);

        wait_ins("ins0");
        check_eq("ins0_word",  ins,     32'h13);
        check_eq("ins0_pc",    jp_pc,   32'h0);
        check_eq("ins0_jflag", jp_flag, 0);
        wait_req("addr4", 32'h4);
        wait_ins("ins4");
        check_eq("ins4_pc", jp_pc, 32'h4);
        wait_req("addr8", 32'h8);

        wait_ins("jal");
        check_eq("jal_word",  ins,     32'h0100_006F);
        check_eq("jal_pc",    jp_pc,   32'h8);
        check_eq("jal_jflag", jp_flag, 1);
        wait_req("jal_target", 32'h18);

        stall_IF = 1'b1;
        wait_ins("ins24");
        check_eq("ins24_pc", jp_pc, 32'h18);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(ins_flag && ins == 32'h13 && jp_pc == 32'h18 && !mem_req)) stable = 1'b0;
        end
        check_eq("stall_stable", stable, 1);
        stall_IF = 1'b0;
        wait_req("after_stall", 32'h1C);
        check_eq("consumed_flag", ins_flag, 0);
        wait_ins("ins28");
        check_eq("ins28_pc", jp_pc, 32'h1C);

        mem_lat = 4;
        wait_req("addr32", 32'h20);
        @(negedge clk);
        jp_wrong  = 1'b1;
        jp_target = 32'h100;
        @(negedge clk);
        jp_wrong  = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ins_flag) stale = 1'b1;
            if (mem_req && mem_addr != 32'h20) break;
            @(negedge clk);
        end
        check_eq("flush_no_stale", stale, 0);
        check_eq("flush_addr", mem_req ? mem_addr : 32'hDEAD_BEEF, 32'h100);
        mem_lat = 2;
        wait_ins("ins100");
        check_eq("ins100_pc", jp_pc, 32'h100);

        train(32'h40, 1'b1, 3);
        redirect(32'h40);
        wait_ins("br_t");
        check_eq("br_t_word",  ins,     32'h0000_0463);
        check_eq("br_t_pc",    jp_pc,   32'h40);
        check_eq("br_t_jflag", jp_flag, 1);
        wait_req("br_target", 32'h48);

        train(32'h40, 1'b0, 4);
        redirect(32'h40);
        wait_ins("br_nt");
        check_eq("br_nt_pc",    jp_pc,   32'h40);
        check_eq("br_nt_jflag", jp_flag, 0);
        wait_req("br_fall", 32'h44);

        train(32'h40, 1'b1, 1);
        redirect(32'h40);
        wait_ins("sat_low");
        check_eq("sat_low_jflag", jp_flag, 0);

        train(32'h40, 1'b1, 1);
        redirect(32'h40);
        wait_ins("cnt_10");
        check_eq("cnt_10_jflag", jp_flag, 1);

        // Train not-taken on the very edge that captures the branch
        redirect(32'h40);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid && mem_req && mem_addr == 32'h40) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("same_cycle_found", found, 1);
        bp_update = 1'b1;
        bp_pc     = 32'h40;
        bp_taken  = 1'b0;
        @(negedge clk);
        bp_update = 1'b0;
        check_eq("same_cycle_flag",  ins_flag, 1);
        check_eq("same_cycle_jflag", jp_flag,  1);
        redirect(32'h40);
        wait_ins("post_update");
        check_eq("post_update_jflag", jp_flag, 0);

        wait_req("pre_rst", 32'h44);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_mem_req",  mem_req,  0);
        check_eq("mid_rst_mem_addr", mem_addr, 0);
        check_eq("mid_rst_ins_flag", ins_flag, 0);
        check_eq("mid_rst_ins",      ins,      0);
        check_eq("mid_rst_jp_flag",  jp_flag,  0);
        check_eq("mid_rst_jp_pc",    jp_pc,    0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("post_rst_req",  mem_req,  1);
        check_eq("post_rst_addr", mem_addr, 32'h0);
        wait_ins("post_rst_ins");
        check_eq("post_rst_pc",   jp_pc, 32'h0);
        check_eq("post_rst_word", ins,   32'h13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 256, meaning number of 2-bit branch history counters, indexed by pc[9:2].
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rdy, input, 1, global enable; when low, all state holds, except REQ-016.
REQ-006 SHALL have port jp_wrong, input, 1, misprediction flush from ROB.
REQ-007 SHALL have port jp_target, input, 32, correct PC accompanying jp_wrong.
REQ-008 SHALL have ports bp_update (input, 1), bp_pc (input, 32) and bp_taken (input, 1), the committed-branch outcome used for counter training.
REQ-009 SHALL have port stall_IF, input, 1, decoder back-pressure.
REQ-010 SHALL have ports mem_req (output, 1) and mem_addr (output, 32), the instruction memory request.
REQ-011 SHALL have ports mem_valid (input, 1) and mem_data (input, 32), the instruction memory response.
REQ-012 SHALL have ports ins_flag (output, 1), ins (output, 32), jp_flag (output, 1) and jp_pc (output, 32), meaning instruction valid, instruction word, predicted-taken, and the PC of ins.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_MEM, HOLD and DROP.
REQ-014 IDLE SHALL assert mem_req with mem_addr=pc and move to WAIT_MEM on the next edge.
REQ-015 WAIT_MEM SHALL keep mem_req and mem_addr stable until mem_valid; on mem_valid it SHALL latch ins=mem_data, jp_pc=pc and jp_flag=prediction, set ins_flag=1, update pc to the predicted next PC, and move to HOLD.
REQ-016 jp_wrong SHALL take priority over every other event, irrespective of rdy.
REQ-017 On jp_wrong: pc<=jp_target and ins_flag<=0 on the next edge; the state SHALL become DROP if a request is outstanding without mem_valid in that cycle, otherwise IDLE.
REQ-018 HOLD SHALL keep ins, ins_flag, jp_flag and jp_pc unchanged while stall_IF=1.
REQ-019 In HOLD, at an edge with stall_IF=0 the instruction is consumed: ins_flag<=0 and the state moves to IDLE.
REQ-020 DROP SHALL discard the response at mem_valid without presenting it, then move to IDLE.
REQ-021 Prediction: opcode 111 (JAL) SHALL be taken, target pc+sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
REQ-022 Prediction: opcode 99 (branch) SHALL be taken iff counter[pc[9:2]][1]=1, target pc+sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
REQ-023 Prediction: every other opcode, including JALR, SHALL be not-taken with next PC pc+4.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32.
REQ-025 bp_update SHALL increment counter[bp_pc[9:2]] when bp_taken=1, else decrement it, saturating at 2'b11 and 2'b00.
REQ-026 When an update and a lookup hit the same index in the same cycle, the lookup SHALL use the pre-update value.
REQ-027 Nothing SHALL ever be presented from a fetch issued before a jp_wrong.

Reset
REQ-028 While rst=0: pc=RESET_PC, state=IDLE, ins_flag=0, ins=0, jp_flag=0, jp_pc=0, mem_req=0 and mem_addr=0.
REQ-029 While rst=0, every counter SHALL be 2'b01 (weakly not-taken).
REQ-030 The first mem_req SHALL assert in the first rdy=1 cycle after rst rises.
REQ-031 Reset asserted mid-transaction SHALL abandon that transaction; the memory side ignores the orphan response.

Structure
REQ-032 A shared package SHALL hold the opcode constants (7'd99, 7'd111, 7'd103), the FSM state encoding, and the BHT_ENTRIES and RESET_PC defaults.
REQ-033 The counter table plus its update and lookup logic SHALL be one sub-module, branch_predictor; inst_fetch instantiates it once.

Verification
REQ-034 Reset release, memory returning 32'h00000013 after 2 cycles: mem_addr=0, then ins_flag=1, ins=32'h13, jp_pc=0, jp_flag=0, and next mem_addr=4.
REQ-035 pc=8 fetches 32'h0100006F (jal x0,16): jp_flag=1, next mem_addr=24.
REQ-036 Three bp_update taken at bp_pc=32'h40, then the branch at 32'h40 is fetched: jp_flag=1; after four not-taken updates, jp_flag=0 and the counter reads 00, not wrapped.
REQ-037 stall_IF=1 for 5 cycles in HOLD: ins and ins_flag stable for all 5; exactly one consumption, and the next request issues after stall_IF falls.
REQ-038 jp_wrong with jp_target=32'h100 while in WAIT_MEM, mem_valid 3 cycles later: no ins_flag for the stale word; next mem_addr=32'h100.
REQ-039 rst pulled low during WAIT_MEM: all outputs reach REQ-028 values without a clock edge, and the first post-reset mem_addr=RESET_PC.
